// File: rtl/pcm_rom_arbiter_if.sv
// Requester and PCM ROM handshake bundle for pcm_rom_arbiter.
// slave = arbiter side, master = requesters/ROM side.
interface pcm_rom_arbiter_if #(
    parameter int AW = 20
);
    logic          req0_cs;
    logic [AW-1:0] req0_addr;
    logic [7:0]    req0_data;
    logic          req0_ok;
    logic          req1_cs;
    logic [AW-1:0] req1_addr;
    logic [7:0]    req1_data;
    logic          req1_ok;
    logic          pcm_cs;
    logic [AW-1:0] pcm_addr;
    logic [7:0]    pcm_dout;
    logic          pcm_ok;

    modport slave (
        input  req0_cs, req0_addr, req1_cs, req1_addr, pcm_dout, pcm_ok,
        output req0_data, req0_ok, req1_data, req1_ok, pcm_cs, pcm_addr
    );

    modport master (
        output req0_cs, req0_addr, req1_cs, req1_addr, pcm_dout, pcm_ok,
        input  req0_data, req0_ok, req1_data, req1_ok, pcm_cs, pcm_addr
    );
endinterface

// File: rtl/pcm_rom_arbiter.sv
// Two-requester PCM ROM arbiter with a one-byte tag/data cache per jt6295 engine.
// Optional forced-completion watchdog: define PCM_ARB_TIMEOUT_EN.
module pcm_rom_arbiter #(
    parameter int AW      = 20,
    parameter int OK_DLY  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK96,
    input  logic                 RESET96_N,
    input  logic                 flush,
    pcm_rom_arbiter_if.slave     bus,
    output logic                 grant,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t        state_r;
    logic          pcm_cs_r;
    logic [AW-1:0] pcm_addr_r;
    logic [AW-1:0] lat_addr_r;
    logic [CW-1:0] cnt_r;
    logic          fl_pend_r;
    logic          grant_r;
    logic          last_r;
    logic          busy_r;
    logic          terr_r;
    logic          valid0_r;
    logic          valid1_r;
    logic [AW-1:0] tag0_r;
    logic [AW-1:0] tag1_r;
    logic [7:0]    data0_r;
    logic [7:0]    data1_r;

    logic          hit0_s;
    logic          hit1_s;
    logic          miss0_s;
    logic          miss1_s;
    logic          gnt_s;
    logic [AW-1:0] gnt_addr_s;
    logic          accept_s;
    logic          tmo_s;

`ifdef PCM_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
`endif

    // Hit/miss detection, round-robin pick and ROM return qualification
    always_comb begin
        hit0_s  = bus.req0_cs & valid0_r & (tag0_r == bus.req0_addr);
        hit1_s  = bus.req1_cs & valid1_r & (tag1_r == bus.req1_addr);
        miss0_s = bus.req0_cs & ~hit0_s;
        miss1_s = bus.req1_cs & ~hit1_s;
        if (miss0_s & miss1_s) begin
            gnt_s = ~last_r;
        end else if (miss1_s) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
        gnt_addr_s = gnt_s ? bus.req1_addr : bus.req0_addr;
        // pcm_ok right after launch may belong to a previous SDRAM transaction
        accept_s   = (state_r == WAIT) & bus.pcm_ok & (32'(cnt_r) >= 32'(OK_DLY));
`ifdef PCM_ARB_TIMEOUT_EN
        tmo_s = (state_r == WAIT) & ~accept_s & (cnt_r == TO_LAST);
`else
        tmo_s = 1'b0;
`endif
    end

    // Arbitration FSM, ROM launch and per-requester cache fills
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state_r    <= IDLE;
            pcm_cs_r   <= 1'b0;
            pcm_addr_r <= '0;
            lat_addr_r <= '0;
            cnt_r      <= '0;
            fl_pend_r  <= 1'b0;
            grant_r    <= 1'b0;
            last_r     <= 1'b1;
            busy_r     <= 1'b0;
            terr_r     <= 1'b0;
            valid0_r   <= 1'b0;
            valid1_r   <= 1'b0;
            tag0_r     <= '0;
            tag1_r     <= '0;
            data0_r    <= 8'h00;
            data1_r    <= 8'h00;
        end else begin
            if (flush) begin
                valid0_r <= 1'b0;
                valid1_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (miss0_s | miss1_s) begin
                        grant_r    <= gnt_s;
                        pcm_addr_r <= gnt_addr_s;
                        lat_addr_r <= gnt_addr_s;
                        pcm_cs_r   <= 1'b1;
                        cnt_r      <= '0;
                        fl_pend_r  <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        fl_pend_r <= 1'b1;
                    end
                    if (cnt_r != CW'(TIMEOUT)) begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                    // Fill always lands on lat_addr, even if the requester moved on
                    if (accept_s) begin
                        if (grant_r) begin
                            data1_r  <= bus.pcm_dout;
                            tag1_r   <= lat_addr_r;
                            valid1_r <= ~(fl_pend_r | flush);
                        end else begin
                            data0_r  <= bus.pcm_dout;
                            tag0_r   <= lat_addr_r;
                            valid0_r <= ~(fl_pend_r | flush);
                        end
                        pcm_cs_r <= 1'b0;
                        last_r   <= grant_r;
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end else if (tmo_s) begin
                        if (grant_r) begin
                            data1_r  <= 8'h00;
                            valid1_r <= 1'b0;
                        end else begin
                            data0_r  <= 8'h00;
                            valid0_r <= 1'b0;
                        end
                        pcm_cs_r <= 1'b0;
                        terr_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    pcm_cs_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ok   = hit0_s;
    assign bus.req0_data = data0_r;
    assign bus.req1_ok   = hit1_s;
    assign bus.req1_data = data1_r;
    assign bus.pcm_cs    = pcm_cs_r;
    assign bus.pcm_addr  = pcm_addr_r;
    assign grant         = grant_r;
    assign busy          = busy_r;
    assign timeout_err   = terr_r;

endmodule

// File: tb/tb_pcm_rom_arbiter.sv
// Scoreboard bench for pcm_rom_arbiter: expected ROM launches are queued when
// requests are driven and popped when pcm_cs rises; fill data comes from a ROM model.
module tb_pcm_rom_arbiter;
    logic CLK96     = 1'b0;
    logic RESET96_N = 1'b0;
    logic flush     = 1'b0;
    logic grant;
    logic busy;
    logic timeout_err;

    pcm_rom_arbiter_if #(.AW(20)) bus ();

    pcm_rom_arbiter #(.AW(20), .OK_DLY(1), .TIMEOUT(8)) dut (
        .CLK96       (CLK96),
        .RESET96_N   (RESET96_N),
        .flush       (flush),
        .bus         (bus),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 CLK96 = ~CLK96;

    typedef struct {
        logic        g;
        logic [19:0] addr;
    } fetch_t;

    fetch_t sb_q[$];
    int     n_chk  = 0;
    int     n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] rom_byte(input logic [19:0] a);
        if (a == 20'h01234) return 8'h5A;
        return a[7:0] ^ a[19:12] ^ 8'h3C;
    endfunction

    task automatic tick();
        @(posedge CLK96);
        #1;
    endtask

    task automatic push(input logic g, input logic [19:0] a);
        fetch_t f;
        f.g    = g;
        f.addr = a;
        sb_q.push_back(f);
    endtask

    task automatic do_reset();
        RESET96_N     = 1'b0;
        flush         = 1'b0;
        bus.req0_cs   = 1'b0;
        bus.req0_addr = 20'h0;
        bus.req1_cs   = 1'b0;
        bus.req1_addr = 20'h0;
        bus.pcm_ok    = 1'b0;
        bus.pcm_dout  = 8'h00;
        tick();
        tick();
        check_val("rst_pcm_cs", 32'(bus.pcm_cs), 32'd0);
        check_val("rst_pcm_addr", 32'(bus.pcm_addr), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_terr", 32'(timeout_err), 32'd0);
        RESET96_N = 1'b1;
        #1;
    endtask

    // One edge after the miss is presented, pcm_cs must be up for the queued fetch
    task automatic expect_launch();
        fetch_t f;
        tick();
        check_val("launch_cs", 32'(bus.pcm_cs), 32'd1);
        check_val("launch_busy", 32'(busy), 32'd1);
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            f = sb_q.pop_front();
            check_val("launch_addr", 32'(bus.pcm_addr), 32'(f.addr));
            check_val("launch_grant", 32'(grant), 32'(f.g));
        end
    endtask

    // ROM answers dly cycles after launch; fl pulses flush in the accept cycle
    task automatic serve(input int dly, input logic fl);
        repeat (dly) tick();
        check_val("wait_cs", 32'(bus.pcm_cs), 32'd1);
        bus.pcm_ok   = 1'b1;
        bus.pcm_dout = rom_byte(bus.pcm_addr);
        flush        = fl;
        tick();
        bus.pcm_ok = 1'b0;
        flush      = 1'b0;
        #1;
        check_val("done_cs", 32'(bus.pcm_cs), 32'd0);
        check_val("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;

        // Single miss, 3-cycle ROM, then repeat hits without new fetch
        do_reset();
        bus.req0_cs   = 1'b1;
        bus.req0_addr = 20'h01234;
        push(1'b0, 20'h01234);
        #1;
        check_val("t1_pre_ok", 32'(bus.req0_ok), 32'd0);
        expect_launch();
        serve(3, 1'b0);
        check_val("t1_ok", 32'(bus.req0_ok), 32'd1);
        check_val("t1_data", 32'(bus.req0_data), 32'h5A);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t1_no_refetch", 32'(bus.pcm_cs), 32'd0);
            check_val("t1_hit", 32'(bus.req0_ok), 32'd1);
        end

        // Simultaneous misses after reset: 0 first, then 1, next tie back to 0
        do_reset();
        bus.req0_cs   = 1'b1;
        bus.req0_addr = 20'h00010;
        bus.req1_cs   = 1'b1;
        bus.req1_addr = 20'h40020;
        push(1'b0, 20'h00010);
        push(1'b1, 20'h40020);
        expect_launch();
        serve(1, 1'b0);
        check_val("t2_ok0", 32'(bus.req0_ok), 32'd1);
        check_val("t2_data0", 32'(bus.req0_data), 32'(rom_byte(20'h00010)));
        expect_launch();
        check_val("t2_hit_during_wait", 32'(bus.req0_ok), 32'd1);
        serve(1, 1'b0);
        check_val("t2_ok1", 32'(bus.req1_ok), 32'd1);
        check_val("t2_data1", 32'(bus.req1_data), 32'(rom_byte(20'h40020)));
        bus.req0_addr = 20'h00011;
        bus.req1_addr = 20'h40021;
        push(1'b0, 20'h00011);
        push(1'b1, 20'h40021);
        expect_launch();
        serve(1, 1'b0);
        expect_launch();
        serve(1, 1'b0);
        check_val("t2_ok1b", 32'(bus.req1_ok), 32'd1);
        check_val("t2_data0b", 32'(bus.req0_data), 32'(rom_byte(20'h00011)));

        // Stale ok: pcm_ok held high, not accepted in the launch cycle
        bus.req1_cs   = 1'b0;
        bus.req0_addr = 20'h00200;
        bus.pcm_ok    = 1'b1;
        bus.pcm_dout  = rom_byte(20'h00200);
        push(1'b0, 20'h00200);
        expect_launch();
        check_val("t3_ok_early", 32'(bus.req0_ok), 32'd0);
        tick();
        check_val("t3_stale_hold", 32'(bus.pcm_cs), 32'd1);
        tick();
        bus.pcm_ok = 1'b0;
        #1;
        check_val("t3_done_cs", 32'(bus.pcm_cs), 32'd0);
        check_val("t3_ok", 32'(bus.req0_ok), 32'd1);
        check_val("t3_data", 32'(bus.req0_data), 32'(rom_byte(20'h00200)));

        // Address change mid-fetch: old tag stored, new address refetched
        bus.req0_cs   = 1'b0;
        bus.req1_cs   = 1'b1;
        bus.req1_addr = 20'h00100;
        push(1'b1, 20'h00100);
        expect_launch();
        bus.req1_addr = 20'h00101;
        serve(2, 1'b0);
        check_val("t4_new_miss", 32'(bus.req1_ok), 32'd0);
        bus.req1_addr = 20'h00100;
        #1;
        check_val("t4_old_tag", 32'(bus.req1_ok), 32'd1);
        check_val("t4_old_data", 32'(bus.req1_data), 32'(rom_byte(20'h00100)));
        bus.req1_addr = 20'h00101;
        push(1'b1, 20'h00101);
        expect_launch();
        serve(1, 1'b0);
        check_val("t4_ok", 32'(bus.req1_ok), 32'd1);
        check_val("t4_data", 32'(bus.req1_data), 32'(rom_byte(20'h00101)));

        // Flush in the accept cycle wins; flush also drops requester 1's entry
        bus.req1_cs   = 1'b0;
        bus.req0_cs   = 1'b1;
        bus.req0_addr = 20'h00300;
        push(1'b0, 20'h00300);
        expect_launch();
        serve(1, 1'b1);
        check_val("t5_flush_ok", 32'(bus.req0_ok), 32'd0);
        push(1'b0, 20'h00300);
        expect_launch();
        serve(1, 1'b0);
        check_val("t5_refetch_ok", 32'(bus.req0_ok), 32'd1);
        bus.req0_cs   = 1'b0;
        bus.req1_cs   = 1'b1;
        bus.req1_addr = 20'h00101;
        push(1'b1, 20'h00101);
        expect_launch();
        serve(1, 1'b0);
        check_val("t5_ok1", 32'(bus.req1_ok), 32'd1);

        // Flush earlier in WAIT: result stored invalid, then refetched
        bus.req1_cs   = 1'b0;
        bus.req0_cs   = 1'b1;
        bus.req0_addr = 20'h00500;
        push(1'b0, 20'h00500);
        expect_launch();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        serve(1, 1'b0);
        check_val("t6_flpend_ok", 32'(bus.req0_ok), 32'd0);
        push(1'b0, 20'h00500);
        expect_launch();
        serve(1, 1'b0);
        check_val("t6_ok", 32'(bus.req0_ok), 32'd1);

`ifdef PCM_ARB_TIMEOUT_EN
        // ROM never answers: forced completion after TIMEOUT WAIT cycles
        bus.req0_addr = 20'h00700;
        push(1'b0, 20'h00700);
        expect_launch();
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus.pcm_cs) break;
            n++;
        end
        check_val("t7_wait_cycles", 32'(n), 32'd8);
        check_val("t7_terr", 32'(timeout_err), 32'd1);
        check_val("t7_ok", 32'(bus.req0_ok), 32'd0);
`else
        n = 0;
        check_val("t7_terr_tied", 32'(timeout_err), 32'(n));
`endif

        // Reset mid-WAIT, then a late pcm_ok is ignored
        do_reset();
        bus.req0_cs   = 1'b1;
        bus.req0_addr = 20'h00600;
        push(1'b0, 20'h00600);
        expect_launch();
        tick();
        RESET96_N = 1'b0;
        #1;
        check_val("t8_async_cs", 32'(bus.pcm_cs), 32'd0);
        check_val("t8_async_busy", 32'(busy), 32'd0);
        do_reset();
        bus.pcm_ok   = 1'b1;
        bus.pcm_dout = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("t8_late_busy", 32'(busy), 32'd0);
            check_val("t8_late_cs", 32'(bus.pcm_cs), 32'd0);
        end
        bus.pcm_ok = 1'b0;

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pcm_rom_arbiter.md
Name: pcm_rom_arbiter

Overview:
- Shares one PCM ROM port (SDRAM-side cs/addr/dout/ok) between two jt6295 ADPCM engines in the sound subsystem.
- Each requester keeps the jt6295 ROM contract: it presents an address and waits for ok.
- The block keeps a one-byte tag/data register per requester and fetches misses through a round-robin FSM.
- Requesters supply already-banked 20-bit ROM addresses; bank mapping sits upstream.

Parameters:
- AW, 20, ROM byte address width.
- OK_DLY, 1, cycles after pcm_cs/pcm_addr launch during which pcm_ok is ignored (stale-ok masking).
- TIMEOUT, 255, max WAIT cycles before forced completion (used only with the optional feature).

Ports:
- CLK96  in  1  sound-domain clock.
- RESET96_N  in  1  reset; asynchronous, active-low.
- flush  in  1  pulse; invalidates both tag registers (OKI bank switch).
- req0_cs  in  1  requester 0 wants data.
- req0_addr  in  AW  requester 0 byte address.
- req0_data  out  8  requester 0 byte.
- req0_ok  out  1  req0_data valid for current req0_addr.
- req1_cs / req1_addr / req1_data / req1_ok  same as requester 0.
- pcm_cs  out  1  ROM request.
- pcm_addr  out  AW  ROM address.
- pcm_dout  in  8  ROM data.
- pcm_ok  in  1  ROM data valid.
- grant  out  1  index of requester being served; meaningful while busy.
- busy  out  1  FSM not IDLE.
- timeout_err  out  1  sticky; set on forced completion (optional feature only, else tied 0).

Behaviour:
- Reset values: pcm_cs=0, pcm_addr=0, valid0=valid1=0, tag0=tag1=0, data0=data1=0, grant=0, last=1 (requester 0 wins first tie), busy=0, timeout_err=0, state=IDLE, cnt=0.
- Hit, combinational: hit_i = req_i_cs & valid_i & (tag_i == req_i_addr).
- Outputs: req_i_ok = hit_i; req_i_data = data_i (registered). miss_i = req_i_cs & ~hit_i.
- FSM states IDLE, WAIT.
- IDLE:
  - Neither miss: stay.
  - One miss: grant that requester.
  - Both miss: grant ~last.
  - On grant, next edge: pcm_addr <= req_g_addr, lat_addr <= same, pcm_cs <= 1, cnt <= 0, fl_pend <= 0, state <= WAIT.
- WAIT:
  - cnt increments, saturating at TIMEOUT.
  - pcm_ok is accepted only when cnt >= OK_DLY.
  - On accept: data_g <= pcm_dout, tag_g <= lat_addr, valid_g <= ~(fl_pend | flush), pcm_cs <= 0, last <= g, state <= IDLE.
- Latency: with a granted miss seen in cycle N, pcm_cs rises at N+1. Accepted pcm_ok in cycle K gives req_ok high in K+1 (if the address is unchanged). Back-to-back fills are possible: IDLE may re-grant in the cycle after return.
- Requester changes address or drops cs during WAIT: the fetch completes to lat_addr and the tag is stored. The new address misses and is fetched later. No abort.
- flush:
  - Clears valid0/valid1 on the next edge, in any state.
  - During WAIT it sets fl_pend, so the in-flight result is stored with valid=0.
  - flush and acceptance in the same cycle: flush wins.
- A fill never touches the other requester's registers. A hit on the non-granted requester is served during WAIT.
- pcm_addr holds its value while pcm_cs=0. pcm_ok while in IDLE is ignored.
- Reset mid-WAIT: immediate return to reset values. A late pcm_ok after reset release is ignored (state IDLE).

Optional Feature:
- Macro PCM_ARB_TIMEOUT_EN.
- Defined:
  - In WAIT, if cnt reaches TIMEOUT without an accepted pcm_ok, force completion: data_g <= 8'h00, valid_g <= 0, pcm_cs <= 0, timeout_err <= 1 (sticky until reset), state <= IDLE.
- Undefined:
  - WAIT lasts until pcm_ok; timeout_err constant 0; the cnt compare against TIMEOUT is removed.

Test Plan:
- Single miss: req0_cs=1, req0_addr=0x01234; ROM returns 0x5A with pcm_ok 3 cycles after pcm_cs -> pcm_addr=0x01234 one cycle after request; req0_ok=1, req0_data=0x5A the cycle after pcm_ok; a repeat read of the same address hits with no new pcm_cs.
- Simultaneous misses after reset: req0 at 0x00010, req1 at 0x40020 in the same cycle -> requester 0 served first, then requester 1; the next tie grants 0 again (last=1).
- Stale ok: pcm_ok held high continuously, OK_DLY=1 -> no acceptance in the launch cycle; data captured at cnt=1.
- Address change mid-fetch: req1_addr 0x00100 -> 0x00101 during WAIT -> tag1=0x00100 stored, req1_ok=0, second fetch issued for 0x00101.
- Flush collision: flush pulsed in the same cycle pcm_ok is accepted -> valid_g=0, req_ok stays 0, refetch issued.
- PCM_ARB_TIMEOUT_EN with TIMEOUT=8 and pcm_ok never asserted -> pcm_cs drops after 8 WAIT cycles, timeout_err=1, req_ok remains 0.
